// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 scan-code constants, parser state encoding and code classification helpers
// for the note key tracker.
package ps2_kbd_pkg;

  typedef logic [7:0] scan_code_t;

  localparam scan_code_t PS2_EXT = 8'hE0;
  localparam scan_code_t PS2_BRK = 8'hF0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Keyboard housekeeping bytes (self-test, ack, resend, error) that never name a key.
  function automatic logic is_ignored(input scan_code_t code);
    case (code)
      8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic is_keypad(input scan_code_t code);
    case (code)
      8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73,
      8'h74, 8'h6C, 8'h75, 8'h7D:        return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_key_slot.sv
// One voice slot: holds the most recent make code until its matching break arrives.
// With PS2_AUTO_RELEASE_EN defined, a per-slot timeout also releases a key whose break was lost.
module ps2_key_slot
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TO_W           = 26
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       make_en_i,
  input  logic       brk_en_i,
  input  scan_code_t code_i,
  output scan_code_t code_o,
  output logic       changed_o
);

  scan_code_t code_q, code_d;
  logic       changed_q;

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_to_w_check
    $error("ps2_key_slot: TO_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef PS2_AUTO_RELEASE_EN
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            expire;

  assign expire = (code_q != '0) && (cnt_q == TO_W'(1));

  // A make always wins over a same-cycle expiry and re-arms the timeout.
  always_comb begin
    code_d = code_q;
    cnt_d  = cnt_q;
    if (make_en_i) begin
      code_d = code_i;
      cnt_d  = TO_LOAD;
    end else begin
      if ((brk_en_i && (code_i == code_q)) || expire) begin
        code_d = '0;
      end
      if (code_d == '0) begin
        cnt_d = '0;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    code_d = code_q;
    if (make_en_i) begin
      code_d = code_i;
    end else if (brk_en_i && (code_i == code_q)) begin
      code_d = '0;
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      code_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      code_q    <= code_d;
      changed_q <= (code_d != code_q);
    end
  end

  assign code_o    = code_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/ps2_note_key_tracker.sv
// PS/2 scan-code parser feeding two note slots: main-block keys to slot A, keypad keys to slot B.
// Optional per-slot auto-release is enabled by defining PS2_AUTO_RELEASE_EN.
module ps2_note_key_tracker
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned TO_W           = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_en,
  output logic [7:0] key_code_a,
  output logic [7:0] key_code_b,
  output logic       key_event
);

  logic [1:0] state_q, state_d;
  logic       makeEn, brkEn, keypadCode;
  logic       changedA, changedB;

  // Extended-prefixed sequences are swallowed: no extended key is a note.
  always_comb begin
    state_d = state_q;
    makeEn  = 1'b0;
    brkEn   = 1'b0;
    if (ps2_byte_en) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_byte == PS2_EXT) begin
            state_d = ST_EXT;
          end else if (ps2_byte == PS2_BRK) begin
            state_d = ST_BRK;
          end else if (!is_ignored(ps2_byte)) begin
            makeEn = 1'b1;
          end
        end
        ST_BRK: begin
          brkEn   = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          state_d = (ps2_byte == PS2_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign keypadCode = is_keypad(ps2_byte);

  ps2_key_slot #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_slot_a (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .make_en_i(makeEn && !keypadCode),
    .brk_en_i (brkEn && !keypadCode),
    .code_i   (ps2_byte),
    .code_o   (key_code_a),
    .changed_o(changedA)
  );

  ps2_key_slot #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_slot_b (
    .clk_i    (CLOCK_50),
    .rst_i    (reset),
    .make_en_i(makeEn && keypadCode),
    .brk_en_i (brkEn && keypadCode),
    .code_i   (ps2_byte),
    .code_o   (key_code_b),
    .changed_o(changedB)
  );

  assign key_event = changedA | changedB;

endmodule

// File: tb/tb_ps2_note_key_tracker.sv
// Directed self-checking bench for ps2_note_key_tracker; the auto-release scenario
// follows PS2_AUTO_RELEASE_EN with TIMEOUT_CYCLES=100.
module tb_ps2_note_key_tracker;

  logic       CLOCK_50;
  logic       reset;
  logic [7:0] ps2_byte;
  logic       ps2_byte_en;
  logic [7:0] key_code_a;
  logic [7:0] key_code_b;
  logic       key_event;

  int checks;
  int errors;
  int evCount;

  ps2_note_key_tracker #(
    .TIMEOUT_CYCLES(100),
    .TO_W          (26)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .ps2_byte   (ps2_byte),
    .ps2_byte_en(ps2_byte_en),
    .key_code_a (key_code_a),
    .key_code_b (key_code_b),
    .key_event  (key_event)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Each key_event pulse spans exactly one falling edge.
  always @(negedge CLOCK_50) begin
    if (key_event === 1'b1) evCount++;
  end

  // Drives one strobed byte; returns #1 after the sampling edge.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLOCK_50);
    ps2_byte    = b;
    ps2_byte_en = 1'b1;
    @(posedge CLOCK_50);
    #1;
    ps2_byte_en = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    ps2_byte    = 8'h00;
    ps2_byte_en = 1'b0;
    idleCycles(3);
    checks++; if (key_code_a !== 8'h00) begin errors++; $display("[TB] FAIL reset_a: got %h expected 00", key_code_a); end
    checks++; if (key_code_b !== 8'h00) begin errors++; $display("[TB] FAIL reset_b: got %h expected 00", key_code_b); end
    checks++; if (key_event !== 1'b0) begin errors++; $display("[TB] FAIL reset_ev: got %b expected 0", key_event); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    idleCycles(2);
  endtask

  task automatic test_make_break_a;
    applyStimulus(8'h15);
    checks++; if (key_code_a !== 8'h15) begin errors++; $display("[TB] FAIL mb_make_a: got %h expected 15", key_code_a); end
    checks++; if (key_event !== 1'b1) begin errors++; $display("[TB] FAIL mb_make_ev: got %b expected 1", key_event); end
    applyStimulus(8'hF0);
    checks++; if (key_code_a !== 8'h15) begin errors++; $display("[TB] FAIL mb_prefix_a: got %h expected 15", key_code_a); end
    checks++; if (key_event !== 1'b0) begin errors++; $display("[TB] FAIL mb_prefix_ev: got %b expected 0", key_event); end
    applyStimulus(8'h15);
    checks++; if (key_code_a !== 8'h00) begin errors++; $display("[TB] FAIL mb_break_a: got %h expected 00", key_code_a); end
    checks++; if (key_event !== 1'b1) begin errors++; $display("[TB] FAIL mb_break_ev: got %b expected 1", key_event); end
    checks++; if (key_code_b !== 8'h00) begin errors++; $display("[TB] FAIL mb_b_idle: got %h expected 00", key_code_b); end
    idleCycles(1);
    checks++; if (key_event !== 1'b0) begin errors++; $display("[TB] FAIL mb_ev_width: got %b expected 0", key_event); end
  endtask

  task automatic test_two_voices;
    applyStimulus(8'h1C);
    applyStimulus(8'h75);
    checks++; if (key_code_a !== 8'h1C) begin errors++; $display("[TB] FAIL tv_a: got %h expected 1C", key_code_a); end
    checks++; if (key_code_b !== 8'h75) begin errors++; $display("[TB] FAIL tv_b: got %h expected 75", key_code_b); end
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checks++; if (key_code_a !== 8'h00) begin errors++; $display("[TB] FAIL tv_break_a: got %h expected 00", key_code_a); end
    checks++; if (key_code_b !== 8'h75) begin errors++; $display("[TB] FAIL tv_hold_b: got %h expected 75", key_code_b); end
    applyStimulus(8'h7D);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checks++; if (key_code_b !== 8'h7D) begin errors++; $display("[TB] FAIL tv_super_b: got %h expected 7D", key_code_b); end
    applyStimulus(8'hF0);
    applyStimulus(8'h7D);
    checks++; if (key_code_b !== 8'h00) begin errors++; $display("[TB] FAIL tv_break_b: got %h expected 00", key_code_b); end
  endtask

  task automatic test_supersede;
    int ev0;
    applyStimulus(8'h15);
    applyStimulus(8'h1D);
    applyStimulus(8'hF0);
    applyStimulus(8'h15);
    checks++; if (key_code_a !== 8'h1D) begin errors++; $display("[TB] FAIL sup_hold: got %h expected 1D", key_code_a); end
    checks++; if (key_event !== 1'b0) begin errors++; $display("[TB] FAIL sup_no_ev: got %b expected 0", key_event); end
    applyStimulus(8'hF0);
    applyStimulus(8'h1D);
    checks++; if (key_code_a !== 8'h00) begin errors++; $display("[TB] FAIL sup_break: got %h expected 00", key_code_a); end
    idleCycles(2);
    ev0 = evCount;
    applyStimulus(8'h1D);
    applyStimulus(8'h1D);
    applyStimulus(8'h1D);
    idleCycles(2);
    checks++; if (key_code_a !== 8'h1D) begin errors++; $display("[TB] FAIL rep_a: got %h expected 1D", key_code_a); end
    checks++; if (evCount - ev0 !== 1) begin errors++; $display("[TB] FAIL rep_events: got %0d expected 1", evCount - ev0); end
    applyStimulus(8'hF0);
    applyStimulus(8'h1D);
    idleCycles(2);
  endtask

  task automatic test_ext_noise;
    int ev0;
    logic [7:0] seq [7];
    seq = '{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B, 8'hAA, 8'hFA};
    ev0 = evCount;
    for (int i = 0; i < 7; i++) applyStimulus(seq[i]);
    idleCycles(2);
    checks++; if (key_code_a !== 8'h00) begin errors++; $display("[TB] FAIL ext_a: got %h expected 00", key_code_a); end
    checks++; if (key_code_b !== 8'h00) begin errors++; $display("[TB] FAIL ext_b: got %h expected 00", key_code_b); end
    checks++; if (evCount - ev0 !== 0) begin errors++; $display("[TB] FAIL ext_events: got %0d expected 0", evCount - ev0); end
    applyStimulus(8'h16);
    checks++; if (key_code_a !== 8'h16) begin errors++; $display("[TB] FAIL ext_idle_make: got %h expected 16", key_code_a); end
    applyStimulus(8'hF0);
    applyStimulus(8'h16);
    idleCycles(2);
  endtask

  task automatic test_reset_mid;
    applyStimulus(8'h24);
    applyStimulus(8'hF0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    checks++; if (key_code_a !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_a: got %h expected 00", key_code_a); end
    @(negedge CLOCK_50);
    reset = 1'b0;
    applyStimulus(8'h24);
    checks++; if (key_code_a !== 8'h24) begin errors++; $display("[TB] FAIL rst_mid_make: got %h expected 24", key_code_a); end
    checks++; if (key_event !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ev: got %b expected 1", key_event); end
    applyStimulus(8'hF0);
    applyStimulus(8'h24);
    idleCycles(2);
  endtask

`ifdef PS2_AUTO_RELEASE_EN
  task automatic test_auto_release;
    logic sawClear;
    applyStimulus(8'h2D);
    idleCycles(99);
    checks++; if (key_code_a !== 8'h2D) begin errors++; $display("[TB] FAIL ar_before: got %h expected 2D", key_code_a); end
    idleCycles(1);
    checks++; if (key_code_a !== 8'h00) begin errors++; $display("[TB] FAIL ar_expire: got %h expected 00", key_code_a); end
    checks++; if (key_event !== 1'b1) begin errors++; $display("[TB] FAIL ar_expire_ev: got %b expected 1", key_event); end
    sawClear = 1'b0;
    applyStimulus(8'h2D);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 49; c++) begin
        idleCycles(1);
        if (key_code_a !== 8'h2D) sawClear = 1'b1;
      end
      applyStimulus(8'h2D);
      if (key_code_a !== 8'h2D) sawClear = 1'b1;
    end
    checks++; if (sawClear !== 1'b0) begin errors++; $display("[TB] FAIL ar_repeat_hold: got cleared=%b expected 0", sawClear); end
  endtask
`else
  task automatic test_auto_release;
    applyStimulus(8'h2D);
    idleCycles(300);
    checks++; if (key_code_a !== 8'h2D) begin errors++; $display("[TB] FAIL hold_no_timeout: got %h expected 2D", key_code_a); end
    checks++; if (key_event !== 1'b0) begin errors++; $display("[TB] FAIL hold_no_ev: got %b expected 0", key_event); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    evCount = 0;
    test_reset();
    test_make_break_a();
    test_two_voices();
    test_supersede();
    test_ext_noise();
    test_reset_mid();
    test_auto_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
